countdown_ctrl: RTL and testbench
=================================

Name: countdown_ctrl

Overview:
- Run/set/pause/alarm sequencer for the BCD countdown counter.
- Debounces three push-buttons and holds the user preset (00-99 BCD).
- Drives the counter's load and count-enable, and raises the alarm request to the beeper when the count reaches zero.
- Runs on the system clock; timing is qualified by the 1 Hz strobe from the clock divider.

Parameters:
- DEF_H, 4'd6: reset/clear preset tens digit (BCD).
- DEF_L, 4'd0: reset/clear preset units digit (BCD).
- DB_CYCLES, 16'd50000: clock cycles a synchronized key must stay high to count as one press.
- ALARM_SEC, 4'd5: number of tick strobes the alarm stays asserted.

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset (0 = reset).
- tick, input, 1: one-cycle 1 Hz strobe from the divider.
- key_start, input, 1: start/pause button, active-high, asynchronous level.
- key_up, input, 1: preset increment button, active-high, asynchronous level.
- key_clr, input, 1: clear/abort button, active-high, asynchronous level.
- zero, input, 1: counter value == 00 (combinational from counter registers).
- preset_h, output, 4: preset tens digit, BCD.
- preset_l, output, 4: preset units digit, BCD.
- load, output, 1: one-cycle pulse; the counter loads the preset at this clock edge.
- count_en, output, 1: counter decrements on tick while high.
- alarm, output, 1: beeper request.
- state, output, 3: current state encoding, for debug and display.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE(0); preset={DEF_H,DEF_L}.
  - load=0, count_en=0, alarm=0.
  - Debounce counters and sync flops cleared.
- Key front end, per key:
  - 2-flop synchronizer, then a counter of consecutive high cycles.
  - Press event = single-cycle pulse when the counter reaches DB_CYCLES.
  - No further event until the synced level has returned low for at least 1 cycle.
  - Any low sample resets the counter.
  - Latency from a stable key to its event: 2 + DB_CYCLES cycles.
- Simultaneous events:
  - Priority: clr > start > up.
  - Only the highest-priority event acts that cycle; the others are dropped.
  - A key event beats tick and zero in the same cycle.
- States: IDLE=0, SET=1, RUN=2, PAUSE=3, ALARM=4. Outputs are registered.
- IDLE:
  - up: preset+1, go to SET.
  - start: if preset != 00, pulse load and go to RUN; if preset == 00, ignore.
  - clr: preset=default, stay in IDLE.
- SET:
  - up: BCD increment, units 9->0 with carry into tens; 99 wraps to 00.
  - start: same rule as IDLE (00 is ignored, stay in SET).
  - clr: preset=default, go to IDLE.
- RUN:
  - First cycle after entry: load=1, count_en=0.
  - Afterwards: count_en=1.
  - start: count_en=0 next cycle, go to PAUSE.
  - clr: pulse load (reload preset), go to IDLE.
  - zero=1 in any RUN cycle with load=0: count_en=0, alarm=1, go to ALARM.
  - zero is ignored during the load cycle.
  - up: ignored.
- PAUSE:
  - count_en=0.
  - start: go to RUN with no load; count_en=1 next cycle.
  - clr: pulse load, go to IDLE.
  - up: ignored.
- ALARM:
  - alarm=1; an internal counter counts ticks.
  - On the ALARM_SEC-th tick: alarm=0, pulse load, go to IDLE.
  - Any key event ends the alarm early with the same exit.
- Preset is changed only in IDLE and SET; it is held through RUN, PAUSE and ALARM.
- load is never high for 2 consecutive cycles.
- count_en and load are never high together.
- Reset mid-RUN or mid-ALARM: outputs drop immediately (asynchronous); no load pulse is issued.

Test Plan:
- Reset released, no keys -> state=0, preset=0x60, load=0, count_en=0, alarm=0.
- key_up held 3 separate presses (each ≥DB_CYCLES+2) from preset 0x98 -> 0x99, 0x00, 0x01; state=SET; a press shorter than DB_CYCLES gives no change.
- Preset 0x03, start press -> load=1 for exactly 1 cycle, then count_en=1.
  - With the counter model reaching zero after 3 ticks: alarm=1, count_en=0.
  - After 5 ticks: alarm=0, load pulse, state=IDLE.
- RUN, start press -> PAUSE with count_en=0; ticks have no effect; start again -> RUN with count_en=1 and no load pulse.
- Same-cycle clr and start events in RUN -> IDLE with load pulse, no PAUSE; start with preset=0x00 in IDLE -> no state change.
- Assert reset=0 during ALARM -> alarm drops to 0 without waiting for a clock; after release, state=0 and preset=0x60.

Source files
------------

// File: rtl/countdown_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_ctrl
//  Purpose  : Run/set/pause/alarm sequencer for a two-digit BCD countdown
//             counter. Debounces three push-buttons, holds the user preset
//             (00-99 BCD), drives the counter load / count-enable and raises
//             the alarm request when the count reaches zero.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i        system clock, rising edge
//    rst_ni       asynchronous active-low reset
//    tick_i       one-cycle 1 Hz strobe from the divider
//    key_start_i  start/pause button (async level, active-high)
//    key_up_i     preset increment button (async level, active-high)
//    key_clr_i    clear/abort button (async level, active-high)
//    zero_i       counter value == 00
//    preset_h_o   preset tens digit (BCD)
//    preset_l_o   preset units digit (BCD)
//    load_o       one-cycle pulse: counter loads the preset
//    count_en_o   counter decrements on tick while high
//    alarm_o      beeper request
//    state_o      current state (IDLE=0 SET=1 RUN=2 PAUSE=3 ALARM=4)
// ============================================================================
module countdown_ctrl #(
   parameter logic [3:0]  DEF_H     = 4'd6,
   parameter logic [3:0]  DEF_L     = 4'd0,
   parameter logic [15:0] DB_CYCLES = 16'd50000,
   parameter logic [3:0]  ALARM_SEC = 4'd5
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       tick_i,
   input  logic       key_start_i,
   input  logic       key_up_i,
   input  logic       key_clr_i,
   input  logic       zero_i,
   output logic [3:0] preset_h_o,
   output logic [3:0] preset_l_o,
   output logic       load_o,
   output logic       count_en_o,
   output logic       alarm_o,
   output logic [2:0] state_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SET   = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_PAUSE = 3'd3;
   localparam logic [2:0] S_ALARM = 3'd4;

   // Key index: 0 = up, 1 = start, 2 = clr
   logic [2:0] keys_w;
   logic [2:0] ev_w;

   assign keys_w = {key_clr_i, key_start_i, key_up_i};

   // -------------------------------------------------------------------------
   // Key front end: 2-flop synchronizer + consecutive-high counter.
   // The counter saturates at DB_CYCLES; held_q blocks repeat events until
   // the synchronized level has gone low again.
   // -------------------------------------------------------------------------
   for (genvar k = 0; k < 3; k++) begin : g_key
      logic        s1_q;
      logic        s2_q;
      logic        held_q;
      logic [15:0] cnt_q;

      assign ev_w[k] = s2_q && (cnt_q == DB_CYCLES) && !held_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            held_q <= 1'b0;
            cnt_q  <= 16'd0;
         end else begin
            s1_q <= keys_w[k];
            s2_q <= s1_q;
            if (!s2_q) begin
               cnt_q  <= 16'd0;
               held_q <= 1'b0;
            end else begin
               if (cnt_q != DB_CYCLES) begin
                  cnt_q <= cnt_q + 16'd1;
               end
               if (ev_w[k]) begin
                  held_q <= 1'b1;
               end
            end
         end
      end
   end

   // Priority resolution: clr > start > up; lower ones are dropped.
   logic clr_ev_w;
   logic start_ev_w;
   logic up_ev_w;
   logic any_ev_w;

   assign clr_ev_w   = ev_w[2];
   assign start_ev_w = ev_w[1] && !ev_w[2];
   assign up_ev_w    = ev_w[0] && !ev_w[1] && !ev_w[2];
   assign any_ev_w   = |ev_w;

   // -------------------------------------------------------------------------
   // Sequencer registers
   // -------------------------------------------------------------------------
   logic [2:0] state_q,    state_d;
   logic [3:0] preset_h_q, preset_h_d;
   logic [3:0] preset_l_q, preset_l_d;
   logic       load_q,     load_d;
   logic       count_en_q, count_en_d;
   logic       alarm_q,    alarm_d;
   logic [3:0] alm_cnt_q,  alm_cnt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         preset_h_q <= DEF_H;
         preset_l_q <= DEF_L;
         load_q     <= 1'b0;
         count_en_q <= 1'b0;
         alarm_q    <= 1'b0;
         alm_cnt_q  <= 4'd0;
      end else begin
         state_q    <= state_d;
         preset_h_q <= preset_h_d;
         preset_l_q <= preset_l_d;
         load_q     <= load_d;
         count_en_q <= count_en_d;
         alarm_q    <= alarm_d;
         alm_cnt_q  <= alm_cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and preset logic
   // -------------------------------------------------------------------------
   logic       preset_nz_w;
   logic [3:0] inc_h_w;
   logic [3:0] inc_l_w;
   logic       alarm_done_w;

   assign preset_nz_w  = (preset_h_q != 4'd0) || (preset_l_q != 4'd0);
   assign alarm_done_w = tick_i && (alm_cnt_q == (ALARM_SEC - 4'd1));

   // BCD increment, 99 wraps to 00
   always_comb begin
      inc_h_w = preset_h_q;
      inc_l_w = preset_l_q + 4'd1;
      if (preset_l_q >= 4'd9) begin
         inc_l_w = 4'd0;
         inc_h_w = (preset_h_q >= 4'd9) ? 4'd0 : preset_h_q + 4'd1;
      end
   end

   always_comb begin
      state_d    = state_q;
      preset_h_d = preset_h_q;
      preset_l_d = preset_l_q;
      case (state_q)
         S_IDLE, S_SET: begin
            if (clr_ev_w) begin
               preset_h_d = DEF_H;
               preset_l_d = DEF_L;
               state_d    = S_IDLE;
            end else if (start_ev_w) begin
               if (preset_nz_w) begin
                  state_d = S_RUN;
               end
            end else if (up_ev_w) begin
               preset_h_d = inc_h_w;
               preset_l_d = inc_l_w;
               state_d    = S_SET;
            end
         end
         S_RUN: begin
            if (clr_ev_w) begin
               state_d = S_IDLE;
            end else if (start_ev_w) begin
               state_d = S_PAUSE;
            end else if (zero_i && !load_q) begin
               // zero is stale during the load cycle, so it is ignored there
               state_d = S_ALARM;
            end
         end
         S_PAUSE: begin
            if (clr_ev_w) begin
               state_d = S_IDLE;
            end else if (start_ev_w) begin
               state_d = S_RUN;
            end
         end
         S_ALARM: begin
            if (any_ev_w || alarm_done_w) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Output logic (registered next cycle)
   // Load accompanies entry into RUN from IDLE/SET and every return to IDLE
   // from RUN/PAUSE/ALARM. If a load was issued in the previous cycle the
   // counter already holds the (unchanged) preset, so the second pulse is
   // suppressed to keep load from being high two cycles in a row.
   // -------------------------------------------------------------------------
   always_comb begin
      load_d     = 1'b0;
      count_en_d = 1'b0;
      alarm_d    = 1'b0;
      alm_cnt_d  = 4'd0;

      if (((state_q == S_IDLE) || (state_q == S_SET)) && (state_d == S_RUN)) begin
         load_d = !load_q;
      end
      if (((state_q == S_RUN) || (state_q == S_PAUSE) || (state_q == S_ALARM)) &&
          (state_d == S_IDLE)) begin
         load_d = !load_q;
      end

      // First RUN cycle after IDLE/SET is the load cycle; counting starts after.
      count_en_d = (state_d == S_RUN) && ((state_q == S_RUN) || (state_q == S_PAUSE));

      alarm_d = (state_d == S_ALARM);

      if ((state_q == S_ALARM) && (state_d == S_ALARM)) begin
         alm_cnt_d = tick_i ? alm_cnt_q + 4'd1 : alm_cnt_q;
      end
   end

   assign preset_h_o = preset_h_q;
   assign preset_l_o = preset_l_q;
   assign load_o     = load_q;
   assign count_en_o = count_en_q;
   assign alarm_o    = alarm_q;
   assign state_o    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_countdown_ctrl
//  Purpose  : Directed self-checking bench for countdown_ctrl, with a small
//             behavioural model of the BCD countdown counter driving zero.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_ctrl;

   localparam logic [15:0] DB = 16'd8;
   localparam int          HOLD = 12;   // > DB + 2 cycles
   localparam logic [2:0]  M_UP = 3'b001;
   localparam logic [2:0]  M_START = 3'b010;
   localparam logic [2:0]  M_CLR = 3'b100;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic       key_start;
   logic       key_up;
   logic       key_clr;
   logic       zero;
   logic [3:0] preset_h;
   logic [3:0] preset_l;
   logic       load;
   logic       count_en;
   logic       alarm;
   logic [2:0] state;

   countdown_ctrl #(
      .DEF_H     (4'd6),
      .DEF_L     (4'd0),
      .DB_CYCLES (DB),
      .ALARM_SEC (4'd5)
   ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .tick_i      (tick),
      .key_start_i (key_start),
      .key_up_i    (key_up),
      .key_clr_i   (key_clr),
      .zero_i      (zero),
      .preset_h_o  (preset_h),
      .preset_l_o  (preset_l),
      .load_o      (load),
      .count_en_o  (count_en),
      .alarm_o     (alarm),
      .state_o     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counter model: value in decimal, loads preset on load, decrements on tick
   int cnt_val = 0;
   always @(posedge clk) begin
      if (load) begin
         cnt_val <= int'(preset_h) * 10 + int'(preset_l);
      end else if (count_en && tick && cnt_val != 0) begin
         cnt_val <= cnt_val - 1;
      end
   end
   assign zero = (cnt_val == 0);

   // Output monitor
   int load_cnt  = 0;
   int dbl_load  = 0;
   int overlap   = 0;
   int saw_pause = 0;
   logic prev_load = 1'b0;
   always @(negedge clk) begin
      if (load) load_cnt++;
      if (load && prev_load) dbl_load++;
      if (load && count_en) overlap++;
      if (state == 3'd3) saw_pause++;
      prev_load = load;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic press(input logic [2:0] m, input int hold);
      @(negedge clk);
      {key_clr, key_start, key_up} = m;
      repeat (hold) @(negedge clk);
      {key_clr, key_start, key_up} = 3'b000;
      repeat (4) @(negedge clk);
   endtask

   task automatic pulse_tick();
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   int ld0;

   initial begin
      rst_n = 1'b0;
      tick = 1'b0;
      {key_clr, key_start, key_up} = 3'b000;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_state", 32'(state), 32'd0);
      check("rst_preset", 32'({preset_h, preset_l}), 32'h60);
      check("rst_load", 32'(load), 32'd0);
      check("rst_cen", 32'(count_en), 32'd0);
      check("rst_alarm", 32'(alarm), 32'd0);

      // Preset 60 -> 98 via 38 up presses, then wrap behaviour
      for (int i = 0; i < 38; i++) press(M_UP, HOLD);
      check("set_98", 32'({preset_h, preset_l}), 32'h98);
      check("set_state", 32'(state), 32'd1);
      press(M_UP, HOLD);
      check("set_99", 32'({preset_h, preset_l}), 32'h99);
      press(M_UP, HOLD);
      check("set_00", 32'({preset_h, preset_l}), 32'h00);
      ld0 = load_cnt;
      press(M_START, HOLD);
      check("start00_state", 32'(state), 32'd1);
      check("start00_noload", 32'(load_cnt - ld0), 32'd0);
      press(M_UP, HOLD);
      check("set_01", 32'({preset_h, preset_l}), 32'h01);
      press(M_UP, int'(DB) - 2);
      check("short_press", 32'({preset_h, preset_l}), 32'h01);
      press(M_UP, HOLD);
      press(M_UP, HOLD);
      check("set_03", 32'({preset_h, preset_l}), 32'h03);

      // Start from 03: single load then counting
      ld0 = load_cnt;
      press(M_START, HOLD);
      check("run_state", 32'(state), 32'd2);
      check("run_load1", 32'(load_cnt - ld0), 32'd1);
      check("run_cen", 32'(count_en), 32'd1);
      pulse_tick();
      pulse_tick();
      check("run_2tick", 32'(state), 32'd2);
      check("run_2tick_alarm", 32'(alarm), 32'd0);
      pulse_tick();
      check("alarm_on", 32'(alarm), 32'd1);
      check("alarm_cen", 32'(count_en), 32'd0);
      check("alarm_state", 32'(state), 32'd4);
      for (int i = 0; i < 4; i++) pulse_tick();
      check("alarm_4tick", 32'(alarm), 32'd1);
      ld0 = load_cnt;
      pulse_tick();
      check("alarm_off", 32'(alarm), 32'd0);
      check("alarm_exit", 32'(state), 32'd0);
      check("alarm_load", 32'(load_cnt - ld0), 32'd1);
      check("preset_held", 32'({preset_h, preset_l}), 32'h03);

      // Pause / resume
      press(M_START, HOLD);
      press(M_START, HOLD);
      check("pause_state", 32'(state), 32'd3);
      check("pause_cen", 32'(count_en), 32'd0);
      pulse_tick();
      pulse_tick();
      check("pause_hold", 32'(cnt_val), 32'd3);
      ld0 = load_cnt;
      press(M_START, HOLD);
      check("resume_state", 32'(state), 32'd2);
      check("resume_cen", 32'(count_en), 32'd1);
      check("resume_noload", 32'(load_cnt - ld0), 32'd0);

      // Simultaneous clr + start in RUN: clr wins
      ld0 = load_cnt;
      saw_pause = 0;
      press(M_CLR | M_START, HOLD);
      check("clr_state", 32'(state), 32'd0);
      check("clr_load", 32'(load_cnt - ld0), 32'd1);
      check("clr_nopause", 32'(saw_pause), 32'd0);
      check("clr_preset", 32'({preset_h, preset_l}), 32'h03);

      // Async reset during ALARM
      press(M_START, HOLD);
      for (int i = 0; i < 3; i++) pulse_tick();
      check("alarm2_on", 32'(alarm), 32'd1);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_alarm_async", 32'(alarm), 32'd0);
      check("rst_state_async", 32'(state), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("rel_state", 32'(state), 32'd0);
      check("rel_preset", 32'({preset_h, preset_l}), 32'h60);

      // Invariants over the whole run
      check("no_double_load", 32'(dbl_load), 32'd0);
      check("no_load_cen", 32'(overlap), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
